vec_wb_stage: RTL and testbench

- Parametrised MEM→WB pipeline stage for the vector datapath, with LANES lanes of N bits.
- Replaces the fixed 8-lane, always-load stage register with a valid/ready pipeline stage built around a 2-entry skid buffer.
- Adds a per-lane write mask, synchronous flush and MemtoReg result selection at stage entry.
- Exposes a forwarding port so the hazard unit can bypass the pending write-back value.

---
 rtl/vec_wb_pkg.sv | 22 ++
 rtl/vec_wb_entry.sv | 20 ++
 rtl/vec_wb_stage.sv | 147 ++++++++++++++
 tb/tb_vec_wb_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_wb_pkg.sv
// Shared types for the vector MEM->WB stage.
// Default geometry, FSM encoding and stored entry layout.
package vec_wb_pkg;

   localparam int N     = 20;
   localparam int LANES = 8;
   localparam int AW    = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [LANES-1:0][N-1:0] data;
      logic [AW-1:0]           wa3;
      logic                    regwrite;
      logic [LANES-1:0]        mask;
   } wb_entry_t;

endpackage

// File: rtl/vec_wb_entry.sv
// Load-enabled payload register holding one write-back entry.
// Used twice by the stage: MAIN and SKID.
module vec_wb_entry #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/vec_wb_stage.sv
// Vector MEM->WB stage: valid/ready skid buffer with result select,
// per-lane write mask, flush and a forwarding view of the head entry.
module vec_wb_stage #(
   parameter int N     = vec_wb_pkg::N,
   parameter int LANES = vec_wb_pkg::LANES,
   parameter int AW    = vec_wb_pkg::AW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES-1:0][N-1:0] in_rd,
   input  logic [LANES-1:0][N-1:0] in_alu,
   input  logic [AW-1:0]           in_wa3,
   input  logic                    in_regwrite,
   input  logic                    in_memtoreg,
   input  logic [LANES-1:0]        in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES-1:0][N-1:0] out_wd,
   output logic [AW-1:0]           out_wa3,
   output logic                    out_regwrite,
   output logic [LANES-1:0]        out_mask,
   output logic                    fwd_hit_valid,
   output logic [AW-1:0]           fwd_addr,
   output logic [LANES-1:0][N-1:0] fwd_data,
   output logic [LANES-1:0]        fwd_mask,
   output logic [1:0]              occupancy
);

   import vec_wb_pkg::*;

   typedef struct packed {
      logic [LANES-1:0][N-1:0] data;
      logic [AW-1:0]           wa3;
      logic                    regwrite;
      logic [LANES-1:0]        mask;
   } entry_t;

   localparam int EW = $bits(entry_t);

   wb_state_t state, next_state;
   entry_t    in_e, main_d, main_q, skid_q;
   logic      main_ld, skid_ld, main_from_skid;
   logic      in_xfer, out_xfer;

   assign out_valid = (state != EMPTY);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // Result select and write qualification happen once, at entry.
   always_comb begin
      for (int i = 0; i < LANES; i++)
         in_e.data[i] = in_memtoreg ? in_rd[i] : in_alu[i];
      in_e.wa3      = in_wa3;
      in_e.regwrite = in_regwrite & (|in_mask);
      in_e.mask     = in_mask;
   end

   always_comb begin
      next_state     = state;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_xfer) begin
               next_state = ONE;
               main_ld    = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               next_state = TWO;
               skid_ld    = 1'b1;
            end else if (!in_xfer && out_xfer) begin
               next_state = EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_ld    = 1'b1;
            end
         end
         TWO: begin
            if (out_xfer) begin
               next_state     = ONE;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: next_state = EMPTY;
      endcase
      if (flush) begin
         next_state = EMPTY;
         main_ld    = 1'b0;
         skid_ld    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= next_state;
         in_ready <= (next_state != TWO);
      end
   end

   assign main_d = main_from_skid ? skid_q : in_e;

   vec_wb_entry #(.W(EW)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_ld),
      .d     (main_d),
      .q     (main_q)
   );

   vec_wb_entry #(.W(EW)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_ld),
      .d     (in_e),
      .q     (skid_q)
   );

   // Stale payload after a flush stays hidden behind out_valid.
   assign out_wd       = out_valid ? main_q.data : '0;
   assign out_wa3      = out_valid ? main_q.wa3  : '0;
   assign out_mask     = out_valid ? main_q.mask : '0;
   assign out_regwrite = out_valid & main_q.regwrite;

   assign fwd_hit_valid = out_regwrite;
   assign fwd_addr      = out_wa3;
   assign fwd_data      = out_wd;
   assign fwd_mask      = out_mask;

   always_comb begin
      occupancy = 2'd0;
      unique case (state)
         ONE:     occupancy = 2'd1;
         TWO:     occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_vec_wb_stage.sv
// Self-checking bench for vec_wb_stage: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_vec_wb_stage;

   localparam int N     = 20;
   localparam int LANES = 8;
   localparam int AW    = 4;

   typedef logic [LANES-1:0][N-1:0] vec_t;

   typedef struct packed {
      vec_t             wd;
      logic [AW-1:0]    wa3;
      logic             rw;
      logic [LANES-1:0] mask;
   } ent_t;

   typedef struct {
      logic             m2r;
      logic             rw;
      logic [LANES-1:0] mask;
      logic [AW-1:0]    wa3;
      logic [N-1:0]     rdv;
      logic [N-1:0]     aluv;
      logic [N-1:0]     exp_wd0;
      logic             exp_rw;
   } tvec_t;

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, in_ready;
   vec_t             in_rd, in_alu, out_wd, fwd_data;
   logic [AW-1:0]    in_wa3, out_wa3, fwd_addr;
   logic             in_regwrite, in_memtoreg;
   logic [LANES-1:0] in_mask, out_mask, fwd_mask;
   logic             out_valid, out_ready, out_regwrite, fwd_hit_valid;
   logic [1:0]       occupancy;

   int   tests = 0;
   int   fails = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   vec_wb_stage dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_alu        (in_alu),
      .in_wa3        (in_wa3),
      .in_regwrite   (in_regwrite),
      .in_memtoreg   (in_memtoreg),
      .in_mask       (in_mask),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_wd        (out_wd),
      .out_wa3       (out_wa3),
      .out_regwrite  (out_regwrite),
      .out_mask      (out_mask),
      .fwd_hit_valid (fwd_hit_valid),
      .fwd_addr      (fwd_addr),
      .fwd_data      (fwd_data),
      .fwd_mask      (fwd_mask),
      .occupancy     (occupancy)
   );

   task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // What the spec says gets written: selected data, mask, and a
   // write only if some lane is enabled.
   function automatic ent_t form();
      ent_t e;
      e.wd   = in_memtoreg ? in_rd : in_alu;
      e.wa3  = in_wa3;
      e.mask = in_mask;
      e.rw   = in_regwrite && (in_mask != 0);
      return e;
   endfunction

   task automatic check_model(string tag);
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".occ"},  occupancy, q.size());
      chk({tag, ".rdy"},  in_ready, q.size() < 2);
      chk({tag, ".vld"},  out_valid, q.size() > 0);
      chk({tag, ".wd"},   out_wd, h.wd);
      chk({tag, ".wa3"},  out_wa3, h.wa3);
      chk({tag, ".rw"},   out_regwrite, h.rw);
      chk({tag, ".mask"}, out_mask, h.mask);
      chk({tag, ".fhit"}, fwd_hit_valid, h.rw);
      chk({tag, ".fadr"}, fwd_addr, h.wa3);
      chk({tag, ".fdat"}, fwd_data, h.wd);
      chk({tag, ".fmsk"}, fwd_mask, h.mask);
   endtask

   task automatic tick();
      bit   acc;
      ent_t e;
      acc = in_valid && (q.size() < 2);
      e   = form();
      if (reset || flush) begin
         q.delete();
      end else begin
         if (out_ready && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(logic m2r, logic rw, logic [LANES-1:0] mask,
                         logic [AW-1:0] wa3, logic [N-1:0] rdv,
                         logic [N-1:0] aluv);
      in_memtoreg = m2r;
      in_regwrite = rw;
      in_mask     = mask;
      in_wa3      = wa3;
      for (int k = 0; k < LANES; k++) begin
         in_rd[k]  = rdv + N'(k);
         in_alu[k] = aluv ^ N'(k);
      end
   endtask

   task automatic rand_in();
      in_memtoreg = 1'($urandom);
      in_regwrite = 1'($urandom);
      in_mask     = ($urandom % 4 == 0) ? '0 : LANES'($urandom);
      in_wa3      = AW'($urandom);
      for (int k = 0; k < LANES; k++) begin
         in_rd[k]  = N'($urandom);
         in_alu[k] = N'($urandom);
      end
   endtask

   tvec_t         tv[5];
   logic [AW-1:0] seen[$];
   bit            sent;

   initial begin
      tv[0] = '{1'b0, 1'b1, 8'hFF, 4'd3, 20'h00000, 20'h12345, 20'h12345, 1'b1};
      tv[1] = '{1'b1, 1'b1, 8'h0F, 4'd7, 20'h00000, 20'hFFFFF, 20'h00000, 1'b1};
      tv[2] = '{1'b0, 1'b1, 8'h00, 4'd5, 20'h00111, 20'hABCDE, 20'hABCDE, 1'b0};
      tv[3] = '{1'b1, 1'b0, 8'hFF, 4'hF, 20'h54321, 20'h00000, 20'h54321, 1'b0};
      tv[4] = '{1'b1, 1'b1, 8'h80, 4'd0, 20'hFFFFF, 20'h00001, 20'hFFFFF, 1'b1};

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_in(1'b0, 1'b0, '0, '0, '0, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      check_model("reset");

      for (int t = 0; t < 5; t++) begin
         set_in(tv[t].m2r, tv[t].rw, tv[t].mask, tv[t].wa3,
                tv[t].rdv, tv[t].aluv);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         check_model($sformatf("vec%0d", t));
         chk($sformatf("vec%0d.vld", t), out_valid, 1'b1);
         chk($sformatf("vec%0d.wd0", t), out_wd[0], tv[t].exp_wd0);
         chk($sformatf("vec%0d.rwx", t), out_regwrite, tv[t].exp_rw);
         chk($sformatf("vec%0d.adr", t), out_wa3, tv[t].wa3);
         if (tv[t].m2r && tv[t].rdv == 0)
            for (int k = 0; k < LANES; k++)
               chk($sformatf("vec%0d.lane%0d", t, k), out_wd[k], k);
         tick();
         check_model($sformatf("vec%0d.drain", t));
      end

      // Backpressure: A,B accepted, C held, then all delivered in order.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(1'b0, 1'b1, 8'hFF, 4'd1, 20'h0, 20'hAAAAA);
      tick();
      set_in(1'b0, 1'b1, 8'hFF, 4'd2, 20'h0, 20'hBBBBB);
      tick();
      set_in(1'b0, 1'b1, 8'hFF, 4'd3, 20'h0, 20'hCCCCC);
      check_model("bp.full");
      chk("bp.occ2", occupancy, 2);
      chk("bp.rdy0", in_ready, 1'b0);
      tick();
      check_model("bp.hold");
      out_ready = 1'b1;
      seen.delete();
      for (int i = 0; i < 10 && (in_valid || q.size() > 0); i++) begin
         check_model("bp.run");
         if (out_valid) seen.push_back(out_wa3);
         sent = in_valid && (q.size() < 2);
         tick();
         if (sent) in_valid = 1'b0;
      end
      chk("bp.drain", q.size(), 0);
      chk("bp.cnt", seen.size(), 3);
      for (int i = 0; i < seen.size() && i < 3; i++)
         chk($sformatf("bp.ord%0d", i), seen[i], i + 1);

      // Flush while full, with a simultaneous input that must vanish.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(1'b0, 1'b1, 8'hFF, 4'd4, 20'h0, 20'h11111);
      tick();
      set_in(1'b0, 1'b1, 8'hFF, 4'd5, 20'h0, 20'h22222);
      tick();
      chk("fl.occ2", occupancy, 2);
      set_in(1'b0, 1'b1, 8'hFF, 4'd9, 20'h0, 20'h99999);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_model("fl.after");
      chk("fl.occ0", occupancy, 0);
      chk("fl.rdy1", in_ready, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_model("fl.idle");
      end

      // Reset while full and stalled, then recover.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(1'b1, 1'b1, 8'hFF, 4'd6, 20'h33333, 20'h0);
      tick();
      tick();
      chk("rst.occ2", occupancy, 2);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check_model("rst.after");
      chk("rst.wd", out_wd, '0);
      chk("rst.rdy", in_ready, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      set_in(1'b0, 1'b1, 8'h01, 4'd8, 20'h0, 20'h0BEEF);
      tick();
      in_valid = 1'b0;
      check_model("rst.recov");
      chk("rst.recov.wd0", out_wd[0], 20'h0BEEF);
      tick();
      check_model("rst.recov.drain");

      // Randomized traffic against the queue model.
      for (int c = 0; c < 600; c++) begin
         rand_in();
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 40) == 0;
         check_model("rnd");
         tick();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      check_model("rnd.end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
